credit_wrr_arbiter: RTL and testbench

//  Weighted round-robin arbiter gated by downstream credits; picks at most one per-requester FIFO to pop per cycle.

---
 rtl/arb_pkg.sv | 9 +
 rtl/rr_pick.sv | 27 ++
 rtl/credit_wrr_arbiter.sv | 67 ++++++
 tb/tb_credit_wrr_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared widths, weight type and zero-weight rule for the credit-gated weighted round-robin arbiter.
package arb_pkg;
  localparam int QWID_DEF = 4;
  localparam int ZERO_WEIGHT_AS = 1;
  typedef logic [QWID_DEF-1:0] weight_t;
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority search returning the first request at or after start.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  reqs,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          found
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;
  assign dbl = {reqs, reqs} >> start;
  assign rot = dbl[N-1:0];
  always_comb begin
    off = '0;
    for (int j = N - 1; j >= 0; j--)
      if (rot[j]) off = IW'(j);
    found = |rot;
    sum = {1'b0, start} + {1'b0, off};
    idx = !found ? '0 : (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
    pick = found ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;
  end
endmodule

// File: rtl/credit_wrr_arbiter.sv
// credit_wrr_arbiter: weighted round-robin FIFO pop arbiter, one grant per cycle, each grant spends one downstream credit.
module credit_wrr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int QWID        = 4,
  parameter int MAX_CREDITS = 4,
  localparam int IDXW = width_of(NUM_REQS),
  localparam int CWID = width_of(MAX_CREDITS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQS-1:0]      reqs,
  input  logic [NUM_REQS*QWID-1:0] weights,
  input  logic                     credit_ret,
  output logic [NUM_REQS-1:0]      gnt,
  output logic                     gnt_valid,
  output logic [IDXW-1:0]          gnt_idx,
  output logic [CWID-1:0]          credits,
  output logic                     credit_err
);
  logic [IDXW-1:0]     ptr, start, pidx;
  logic [QWID-1:0]     wcnt, wsel, wload;
  logic [NUM_REQS-1:0] pick;
  logic                found, avail, cont;
  assign start = (ptr == IDXW'(NUM_REQS - 1)) ? '0 : ptr + 1'b1;
  rr_pick #(.N(NUM_REQS), .IW(IDXW)) u_pick (
    .reqs  (reqs),
    .start (start),
    .pick  (pick),
    .idx   (pidx),
    .found (found)
  );
  // rst gates the grant so it drops the instant reset asserts, even with reqs still high
  always_comb begin
    avail = rst && credits != '0;
    cont = avail && reqs[ptr] && wcnt != '0;
    gnt = !avail ? '0 : cont ? ({{(NUM_REQS-1){1'b0}}, 1'b1} << ptr) : pick;
    gnt_valid = |gnt;
    gnt_idx = cont ? ptr : (avail && found) ? pidx : '0;
    wsel = weights[int'(pidx)*QWID +: QWID];
    wload = ((wsel < QWID'(ZERO_WEIGHT_AS)) ? QWID'(ZERO_WEIGHT_AS) : wsel) - QWID'(1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= IDXW'(NUM_REQS - 1);
      wcnt <= '0;
      credits <= CWID'(MAX_CREDITS);
      credit_err <= 1'b0;
    end else begin
      if (gnt_valid) begin
        ptr <= gnt_idx;
        wcnt <= cont ? wcnt - 1'b1 : wload;
      end
      if (gnt_valid && !credit_ret)
        credits <= credits - 1'b1;
      else if (!gnt_valid && credit_ret) begin
        if (credits == CWID'(MAX_CREDITS)) credit_err <= 1'b1;
        else credits <= credits + 1'b1;
      end
    end
  end
  a_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
  a_req:    assert property (@(posedge clk) disable iff (!rst) (gnt & ~reqs) == '0);
  a_cred:   assert property (@(posedge clk) disable iff (!rst) gnt_valid |-> credits != '0);
  a_max:    assert property (@(posedge clk) disable iff (!rst) credits <= CWID'(MAX_CREDITS));
endmodule

// File: tb/tb_credit_wrr_arbiter.sv
// tb_credit_wrr_arbiter: directed scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_credit_wrr_arbiter;
  localparam int N = 4;
  localparam int QW = 4;
  localparam int MAXC = 4;
  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  reqs;
  logic [N*QW-1:0] weights;
  logic          credit_ret;
  logic [N-1:0]  gnt;
  logic          gnt_valid;
  logic [1:0]    gnt_idx;
  logic [2:0]    credits;
  logic          credit_err;
  int checks = 0;
  int errors = 0;
  int m_ptr = N - 1;
  int m_wcnt = 0;
  int m_cred = MAXC;
  bit m_err = 1'b0;

  credit_wrr_arbiter #(.NUM_REQS(N), .QWID(QW), .MAX_CREDITS(MAXC)) dut (
    .clk        (clk),
    .rst        (rst),
    .reqs       (reqs),
    .weights    (weights),
    .credit_ret (credit_ret),
    .gnt        (gnt),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .credits    (credits),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // -1 means nobody is granted this cycle
  function automatic int model_pick();
    if (!rst || m_cred == 0 || reqs == '0) return -1;
    if (reqs[m_ptr] && m_wcnt > 0) return m_ptr;
    for (int o = 1; o <= N; o++)
      if (reqs[(m_ptr + o) % N]) return (m_ptr + o) % N;
    return -1;
  endfunction

  function automatic int nxt_wcnt();
    int g = model_pick();
    int w;
    if (g < 0) return m_wcnt;
    if (g == m_ptr && reqs[m_ptr] && m_wcnt > 0) return m_wcnt - 1;
    w = int'(weights[g*QW +: QW]);
    return (w == 0 ? 1 : w) - 1;
  endfunction

  function automatic int raw_cred();
    return m_cred - (model_pick() >= 0 ? 1 : 0) + int'(credit_ret);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ptr <= N - 1;
      m_wcnt <= 0;
      m_cred <= MAXC;
      m_err <= 1'b0;
    end else begin
      m_wcnt <= nxt_wcnt();
      m_ptr <= (model_pick() >= 0) ? model_pick() : m_ptr;
      m_cred <= (raw_cred() > MAXC) ? MAXC : raw_cred();
      m_err <= m_err | (raw_cred() > MAXC);
    end
  end

  always @(negedge clk) begin
    int g;
    g = model_pick();
    check("m_gnt", int'(gnt), g < 0 ? 0 : (1 << g));
    check("m_valid", int'(gnt_valid), g < 0 ? 0 : 1);
    check("m_idx", int'(gnt_idx), g < 0 ? 0 : g);
    check("m_credits", int'(credits), m_cred);
    check("m_err", int'(credit_err), int'(m_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    reqs = '0;
    credit_ret = 1'b0;
    step();
    rst = 1'b1;
  endtask

  int t1[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  int t2[4] = '{0, 0, 0, 2};
  logic [3:0] t4r[9] = '{4'hA, 4'hA, 4'h8, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
  int t4i[9] = '{1, 1, 3, 1, 1, 1, 1, 1, 3};

  initial begin
    rst = 1'b0;
    reqs = 4'hF;
    weights = '0;
    credit_ret = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_idx", int'(gnt_idx), 0);
    check("rst_cred", int'(credits), MAXC);
    check("rst_err", int'(credit_err), 0);
    step();
    rst = 1'b1;
    reqs = 4'hF;
    weights = 16'h2222;
    credit_ret = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("t1_idx", int'(gnt_idx), t1[i]);
      check("t1_cred", int'(credits), MAXC);
      step();
    end
    do_reset();
    reqs = 4'b0101;
    weights = 16'h0103;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_valid", int'(gnt_valid), i < 4 ? 1 : 0);
      check("t2_idx", int'(gnt_idx), i < 4 ? t2[i] : 0);
      check("t2_cred", int'(credits), MAXC - i);
      step();
    end
    credit_ret = 1'b1;
    @(negedge clk);
    check("t3_nogrant", int'(gnt_valid), 0);
    step();
    credit_ret = 1'b0;
    @(negedge clk);
    check("t3_grant", int'(gnt_valid), 1);
    check("t3_cred1", int'(credits), 1);
    step();
    @(negedge clk);
    check("t3_after", int'(gnt_valid), 0);
    check("t3_cred0", int'(credits), 0);
    do_reset();
    weights = 16'h1050;
    credit_ret = 1'b1;
    for (int i = 0; i < 9; i++) begin
      reqs = t4r[i];
      @(negedge clk);
      check("t4_idx", int'(gnt_idx), t4i[i]);
      step();
    end
    do_reset();
    weights = '0;
    reqs = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_valid", int'(gnt_valid), i < 4 ? 1 : 0);
      step();
    end
    do_reset();
    credit_ret = 1'b1;
    @(negedge clk);
    check("t6_err0", int'(credit_err), 0);
    step();
    credit_ret = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_cred", int'(credits), MAXC);
      check("t6_err", int'(credit_err), 1);
      step();
    end
    reqs = 4'hF;
    weights = 16'h3333;
    credit_ret = 1'b1;
    step();
    @(negedge clk);
    check("t6_midturn", int'(gnt_valid), 1);
    #1 rst = 1'b0;
    #1;
    check("t6_async_gnt", int'(gnt), 0);
    check("t6_async_cred", int'(credits), MAXC);
    check("t6_async_err", int'(credit_err), 0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) reqs = N'($urandom);
      if ($urandom_range(0, 15) == 0) weights = (N*QW)'($urandom);
      credit_ret = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) rst = 1'b0;
      step();
      rst = 1'b1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
